// File: rtl/mdu_if.sv
// Request/response bundle between an MDU client (master) and the mdu (slave).
interface mdu_if #(
   parameter int unsigned WIDTH = 32
);
   logic                   start_i;
   logic [1:0]             op_i;
   logic [WIDTH-1:0]       src1_i;
   logic [WIDTH-1:0]       src2_i;
   logic                   annul_i;
   logic                   busy_o;
   logic                   ready_o;
   logic [2*WIDTH-1:0]     result_o;
   logic                   div_by_zero_o;

   // Client side: issues requests, observes status and result.
   modport master (
      output start_i, op_i, src1_i, src2_i, annul_i,
      input  busy_o, ready_o, result_o, div_by_zero_o
   );

   // MDU side: consumes requests, produces status and result.
   modport slave (
      input  start_i, op_i, src1_i, src2_i, annul_i,
      output busy_o, ready_o, result_o, div_by_zero_o
   );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up applied as the result is registered.
// Build option: define MDU_FAST_MUL_EN to replace the iterative multiply
// with a single registered full-width multiply.
module mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic clk,
   input  logic resetn,
   mdu_if.slave bus
);
   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc;      // product high half or partial remainder
   logic [WIDTH-1:0] shreg;    // multiplier bits or dividend/quotient bits
   logic             neg_lo;   // negate product / quotient on completion
   logic             neg_hi;   // negate remainder on completion
   logic             busy_r;
   logic             ready_r;
   logic             dbz_r;
   logic [W2-1:0]    result_r;

   assign bus.busy_o        = busy_r;
   assign bus.ready_o       = ready_r;
   assign bus.div_by_zero_o = dbz_r;
   assign bus.result_o      = result_r;

   // Operand magnitudes and signs for the request presented this cycle.
   logic             is_signed_c;
   logic             s1_neg_c;
   logic             s2_neg_c;
   logic [WIDTH-1:0] mag1_c;
   logic [WIDTH-1:0] mag2_c;
   logic             div_zero_c;
   always_comb begin
      is_signed_c = ~bus.op_i[0];
      s1_neg_c    = is_signed_c & bus.src1_i[WIDTH-1];
      s2_neg_c    = is_signed_c & bus.src2_i[WIDTH-1];
      mag1_c      = s1_neg_c ? WIDTH'(-bus.src1_i) : bus.src1_i;
      mag2_c      = s2_neg_c ? WIDTH'(-bus.src2_i) : bus.src2_i;
      div_zero_c  = (bus.src2_i == '0);
   end

   // One restoring-division step: shift in next dividend bit, trial subtract.
   logic [WIDTH:0]   div_sh_c;
   logic [WIDTH:0]   div_diff_c;
   logic [WIDTH-1:0] div_rem_c;
   logic [WIDTH-1:0] div_quo_c;
   always_comb begin
      div_sh_c   = {acc, shreg[WIDTH-1]};
      div_diff_c = div_sh_c - {1'b0, opnd};
      div_rem_c  = div_diff_c[WIDTH-1:0];
      div_quo_c  = {shreg[WIDTH-2:0], 1'b1};
      if (div_diff_c[WIDTH]) begin
         div_rem_c = div_sh_c[WIDTH-1:0];
         div_quo_c = {shreg[WIDTH-2:0], 1'b0};
      end
   end

   logic [W2-1:0] mul_prod_c;
`ifdef MDU_FAST_MUL_EN
   // Whole magnitude product in one cycle.
   assign mul_prod_c = W2'(opnd) * W2'(shreg);
`else
   // One shift-add step: add multiplicand if multiplier LSB set, shift right.
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH-1:0] mul_acc_c;
   logic [WIDTH-1:0] mul_shr_c;
   always_comb begin
      mul_sum_c = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      mul_acc_c = mul_sum_c[WIDTH:1];
      mul_shr_c = {mul_sum_c[0], shreg[WIDTH-1:1]};
   end
   assign mul_prod_c = {mul_acc_c, mul_shr_c};
`endif

   // Sign-corrected final values for the step that completes an operation.
   logic [W2-1:0]    mul_fix_c;
   logic [WIDTH-1:0] quo_fix_c;
   logic [WIDTH-1:0] rem_fix_c;
   logic             last_c;
   always_comb begin
      mul_fix_c = neg_lo ? W2'(-mul_prod_c) : mul_prod_c;
      quo_fix_c = neg_lo ? WIDTH'(-div_quo_c) : div_quo_c;
      rem_fix_c = neg_hi ? WIDTH'(-div_rem_c) : div_rem_c;
      last_c    = (cnt == CW'(WIDTH - 1));
   end

   // Control FSM and datapath registers; ready/flag default low each cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         cnt      <= '0;
         opnd     <= '0;
         acc      <= '0;
         shreg    <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         busy_r   <= 1'b0;
         ready_r  <= 1'b0;
         dbz_r    <= 1'b0;
         result_r <= '0;
      end else begin
         ready_r <= 1'b0;
         dbz_r   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start_i && !bus.annul_i) begin
                  cnt    <= '0;
                  acc    <= '0;
                  busy_r <= 1'b1;
                  neg_lo <= s1_neg_c ^ s2_neg_c;
                  if (!bus.op_i[1]) begin
                     state  <= S_MUL;
                     opnd   <= mag1_c;
                     shreg  <= mag2_c;
                     neg_hi <= 1'b0;
                  end else if (div_zero_c) begin
                     state    <= S_DONE;
                     ready_r  <= 1'b1;
                     dbz_r    <= 1'b1;
                     result_r <= {bus.src1_i, {WIDTH{1'b1}}};
                  end else begin
                     state  <= S_DIV;
                     opnd   <= mag2_c;
                     shreg  <= mag1_c;
                     neg_hi <= s1_neg_c;
                  end
               end
            end
            S_MUL: begin
               if (bus.annul_i) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else begin
`ifdef MDU_FAST_MUL_EN
                  state    <= S_DONE;
                  ready_r  <= 1'b1;
                  result_r <= mul_fix_c;
`else
                  acc   <= mul_acc_c;
                  shreg <= mul_shr_c;
                  cnt   <= cnt + CW'(1);
                  if (last_c) begin
                     state    <= S_DONE;
                     ready_r  <= 1'b1;
                     result_r <= mul_fix_c;
                  end
`endif
               end
            end
            S_DIV: begin
               if (bus.annul_i) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  acc   <= div_rem_c;
                  shreg <= div_quo_c;
                  cnt   <= cnt + CW'(1);
                  if (last_c) begin
                     state    <= S_DONE;
                     ready_r  <= 1'b1;
                     result_r <= {rem_fix_c, quo_fix_c};
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end
endmodule
